inst_decode_seq: RTL

- Receiving end of the instruction stream driven into Top: inst = {opcode[2:0], A_index[3:0], B_index[3:0], C_index[3:0], imm[ADDR_WIDTH-1:0]} with inst_valid.
- Buffers instructions in a small FIFO and decodes the fields.
- Expands each instruction into a sequence of per-element micro-ops, one per address, for the Frodo matrix datapath, under a valid/ready handshake.

---
 rtl/inst_decode_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/inst_decode_seq.sv
// Instruction buffer + decoder that expands each instruction into per-element micro-ops.
// Optional performance counters are enabled by defining INST_DECODE_PERF_EN.
module inst_decode_seq #(
    parameter int INST_WIDTH = 27,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [1:0]            level,
    output logic                  uop_valid,
    input  logic                  uop_ready,
    output logic [2:0]            uop_op,
    output logic [3:0]            uop_a,
    output logic [3:0]            uop_b,
    output logic [3:0]            uop_c,
    output logic [ADDR_WIDTH-1:0] uop_addr,
    output logic                  uop_last,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
`ifdef INST_DECODE_PERF_EN
    ,
    output logic [15:0]           perf_retired,
    output logic [15:0]           perf_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    logic [INST_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      fill_reg;
    logic                  push;
    logic                  pop;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] count_reg;

    logic [INST_WIDTH-1:0] head;
    logic [2:0]            head_op;
    logic [3:0]            head_a;
    logic [3:0]            head_b;
    logic [3:0]            head_c;
    logic [ADDR_WIDTH-1:0] head_imm;
    logic [ADDR_WIDTH-1:0] level_count;
    logic [ADDR_WIDTH-1:0] head_count;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Ready depends only on the registered fill, so a same-cycle pop never raises it.
    assign inst_ready = (fill_reg != FULL_CNT);
    assign push       = inst_valid && inst_ready;
    assign pop        = (state_reg == IDLE) && (fill_reg != '0);
    assign busy       = (fill_reg != '0) || (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= inst;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_reg <= fill_reg + CNT_W'(1);
            end else if (pop && !push) begin
                fill_reg <= fill_reg - CNT_W'(1);
            end
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign head_op  = head[ADDR_WIDTH+14 -: 3];
    assign head_a   = head[ADDR_WIDTH+11 -: 4];
    assign head_b   = head[ADDR_WIDTH+7 -: 4];
    assign head_c   = head[ADDR_WIDTH+3 -: 4];
    assign head_imm = head[ADDR_WIDTH-1:0];

    always_comb begin
        level_count = ADDR_WIDTH'(1344);
        case (level)
            2'b00:   level_count = ADDR_WIDTH'(640);
            2'b01:   level_count = ADDR_WIDTH'(976);
            default: level_count = ADDR_WIDTH'(1344);
        endcase
    end

    // A zero immediate means "whole matrix for the current security level".
    assign head_count = (head_imm != '0) ? head_imm : level_count;
    assign addr_next  = uop_addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            count_reg <= '0;
            uop_valid <= 1'b0;
            uop_op    <= '0;
            uop_a     <= '0;
            uop_b     <= '0;
            uop_c     <= '0;
            uop_addr  <= '0;
            uop_last  <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        uop_op    <= head_op;
                        uop_a     <= head_a;
                        uop_b     <= head_b;
                        uop_c     <= head_c;
                        uop_addr  <= '0;
                        count_reg <= head_count;
                        if (head_op == OP_NOP) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else if (head_op == OP_ILL) begin
                            illegal <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                            uop_valid <= 1'b1;
                            uop_last  <= (head_count == ADDR_WIDTH'(1));
                        end
                    end
                end
                ISSUE: begin
                    if (uop_ready) begin
                        if (uop_last) begin
                            state_reg <= DONE;
                            uop_valid <= 1'b0;
                            uop_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            uop_addr <= addr_next;
                            uop_last <= (addr_next == count_reg - ADDR_WIDTH'(1));
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef INST_DECODE_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (done && perf_retired != 16'hFFFF) begin
                perf_retired <= perf_retired + 16'd1;
            end
            if (uop_valid && !uop_ready && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule
